ccm_ctr_dec: RTL



---
 rtl/ccm_ctr_dec.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ccm_ctr_dec.sv
// ccm_ctr_dec: byte-serial CCM counter-mode decryptor with optional CBC-MAC tag check
// Ports:
//   clk, reset (async, active-high)
//   msg_start/msg_length/ctr_nonce/ctr_flag : message header, latched on msg_start in IDLE
//   key_aes     : block key, stable for the whole message
//   in_data/in_en/in_ready : ciphertext (then tag) byte stream, taken when in_en & in_ready
//   out_data/out_en/out_last : plaintext byte stream, MS byte of each block first
//   busy        : high whenever a message is in progress
//   tag_done/tag_ok : one-cycle tag verdict
// Build option: define CCM_TAG_CHECK_EN to add the MAC chain and the 16-byte tag phase.
module ccm_ctr_dec #(
    parameter int WIDTH       = 8,
    parameter int WIDTH_NONCE = 100,
    parameter int WIDTH_FLAG  = 8,
    parameter int WIDTH_COUNT = 20,
    parameter int WK          = WIDTH_NONCE + WIDTH_FLAG + WIDTH_COUNT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   msg_start,
    input  logic [WIDTH-1:0]       msg_length,
    input  logic [WIDTH_NONCE-1:0] ctr_nonce,
    input  logic [WIDTH_FLAG-1:0]  ctr_flag,
    input  logic [WK-1:0]          key_aes,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_en,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_en,
    output logic                   out_last,
    output logic                   busy,
    output logic                   tag_done,
    output logic                   tag_ok
);
    localparam int NB = WK / WIDTH;
    localparam int NW = $clog2(NB + 1);
    localparam logic [NW-1:0] NB_M1 = NW'(NB - 1);

    typedef enum logic [2:0] {IDLE, LOAD, XOR, EMIT, TAG} state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_rem;
    logic [WIDTH_COUNT-1:0] r_cnt;
    logic [WIDTH_FLAG-1:0]  r_flag;
    logic [WIDTH_NONCE-1:0] r_nonce;
    logic [WK-1:0]          r_blk;
    logic [WK-1:0]          r_p;
    logic [NW-1:0]          r_n;
    logic [NW-1:0]          r_k;
    logic                   w_acc;
    logic                   w_blk_end;
    logic [WK-1:0]          w_p;

    assign w_acc     = in_en & in_ready;
    // block closes on its 16th byte or on the message's last byte
    assign w_blk_end = (r_n == NB_M1) || (r_rem == WIDTH'(1));
    assign w_p       = r_blk ^ key_aes ^ {r_flag, r_nonce, r_cnt};
    assign busy      = (r_state != IDLE);

`ifdef CCM_TAG_CHECK_EN
    logic [WK-1:0] r_x;
    logic [WK-1:0] w_mask;
    logic [WK-1:0] w_x_next;
    logic [WK-1:0] w_tag;
    // MAC absorbs the plaintext with the pad bytes of a short block zeroed
    assign w_mask   = ~({WK{1'b1}} >> (WIDTH * int'(r_n)));
    assign w_x_next = r_x ^ (w_p & w_mask) ^ key_aes;
    // received tag with its last byte still on in_data, unmasked by E(K, C0)
    assign w_tag    = {r_blk[WK-1:WIDTH], in_data} ^ key_aes ^ {r_flag, r_nonce, {WIDTH_COUNT{1'b0}}};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rem    <= '0;
            r_cnt    <= WIDTH_COUNT'(1);
            r_flag   <= '0;
            r_nonce  <= '0;
            r_blk    <= '0;
            r_p      <= '0;
            r_n      <= '0;
            r_k      <= '0;
            in_ready <= 1'b0;
            out_data <= '0;
            out_en   <= 1'b0;
            out_last <= 1'b0;
            tag_done <= 1'b0;
            tag_ok   <= 1'b0;
`ifdef CCM_TAG_CHECK_EN
            r_x      <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    tag_done <= 1'b0;
                    tag_ok   <= 1'b0;
                    if (msg_start) begin
                        r_cnt   <= WIDTH_COUNT'(1);
                        r_rem   <= msg_length;
                        r_flag  <= ctr_flag;
                        r_nonce <= ctr_nonce;
                        r_blk   <= '0;
                        r_n     <= '0;
`ifdef CCM_TAG_CHECK_EN
                        r_x      <= {ctr_flag, ctr_nonce, WIDTH_COUNT'(msg_length)} ^ key_aes;
                        r_state  <= (msg_length != '0) ? LOAD : TAG;
                        in_ready <= 1'b1;
`else
                        r_state  <= (msg_length != '0) ? LOAD : IDLE;
                        in_ready <= (msg_length != '0);
`endif
                    end
                end
                LOAD: begin
                    if (w_acc) begin
                        r_blk[WK-1-WIDTH*int'(r_n) -: WIDTH] <= in_data;
                        r_rem <= r_rem - 1'b1;
                        r_n   <= r_n + 1'b1;
                        if (w_blk_end) begin
                            r_state  <= XOR;
                            in_ready <= 1'b0;
                        end
                    end
                end
                XOR: begin
                    // first plaintext byte is registered here so out_en rises two cycles after the last accept
                    r_p      <= w_p;
                    r_cnt    <= r_cnt + 1'b1;
                    out_data <= w_p[WK-1 -: WIDTH];
                    out_en   <= 1'b1;
                    out_last <= (r_n == NW'(1)) && (r_rem == '0);
                    r_k      <= NW'(1);
                    r_state  <= EMIT;
`ifdef CCM_TAG_CHECK_EN
                    r_x      <= w_x_next;
`endif
                end
                EMIT: begin
                    if (r_k == r_n) begin
                        out_en   <= 1'b0;
                        out_last <= 1'b0;
                        out_data <= '0;
                        r_blk    <= '0;
                        r_n      <= '0;
`ifdef CCM_TAG_CHECK_EN
                        r_state  <= (r_rem != '0) ? LOAD : TAG;
                        in_ready <= 1'b1;
`else
                        r_state  <= (r_rem != '0) ? LOAD : IDLE;
                        in_ready <= (r_rem != '0);
`endif
                    end else begin
                        out_data <= r_p[WK-1-WIDTH*int'(r_k) -: WIDTH];
                        out_last <= (r_k == r_n - 1'b1) && (r_rem == '0);
                        r_k      <= r_k + 1'b1;
                    end
                end
`ifdef CCM_TAG_CHECK_EN
                TAG: begin
                    if (w_acc) begin
                        r_blk[WK-1-WIDTH*int'(r_n) -: WIDTH] <= in_data;
                        r_n <= r_n + 1'b1;
                        if (r_n == NB_M1) begin
                            tag_done <= 1'b1;
                            tag_ok   <= (w_tag == r_x);
                            in_ready <= 1'b0;
                            r_state  <= IDLE;
                        end
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
